clock_divider_bank: RTL and testbench
=====================================

// Module: clock_divider_bank
//
// PURPOSE
//  Parametrised successor to the single fixed-ratio divider: NUM_CH independent
//  square-wave dividers from one HighClock, each with a runtime divisor, glitch-free
//  divisor update, per-channel enable, a rising-edge strobe and a global phase resync.
//  Feeds peripheral timing (PWM, UART baud, display scan) from the DE0 board clock.
//
// PARAMETERS
//  NUM_CH       4    number of divider channels (1..16)
//  DIV_W        32   divisor/counter width in bits
//  DEFAULT_DIV  0    active divisor of every channel after Reset
//  CH_W         $clog2(NUM_CH), min 1; width of WrChan (derived, not overridden)
//
// PORTS
//  HighClock  in   1        source clock; all logic on posedge
//  Reset      in   1        synchronous, active-high
//  WrEn       in   1        divisor write strobe
//  WrChan     in   CH_W     channel index for write
//  WrDiv      in   DIV_W    new divisor; half-period = WrDiv+1 HighClock cycles
//  ChanEn     in   NUM_CH   per-channel run enable
//  Resync     in   1        one-cycle pulse: restart all channels in phase
//  LowClock   out  NUM_CH   divided square waves, period 2*(div+1) cycles
//  RiseTick   out  NUM_CH   1-cycle strobe, high in the cycle LowClock[i] rises
//
// BEHAVIOUR
//  - Per channel: count[DIV_W], active[DIV_W], pending[DIV_W], pend_vld. All registered.
//  - Reset (priority 1): count=0, active=DEFAULT_DIV, pend_vld=0, LowClock=0, RiseTick=0.
//  - Write: WrEn & WrChan<NUM_CH -> pending[WrChan]<=WrDiv, pend_vld<=1 next edge.
//    WrChan>=NUM_CH ignored. Repeated writes before apply: last wins.
//  - Resync (priority 2, all channels): count<=0, LowClock<=0, RiseTick<=0;
//    if pend_vld, active<=pending, pend_vld<=0. A write in the same cycle is
//    captured into pending and NOT applied by this Resync.
//  - ChanEn[i]=0 (priority 3): same as Resync for channel i only; held each cycle.
//  - Run (ChanEn[i]=1): count==active -> count<=0, LowClock toggles, apply pending
//    as above (glitch-free: ratio changes only at a half-period boundary);
//    else count<=count+1. Write landing on the toggle cycle applies at next toggle.
//  - RiseTick[i]<=1 exactly when LowClock[i] goes 0->1 on that edge, else 0.
//  - div=0: LowClock toggles every cycle (HighClock/2); div=2^DIV_W-1 legal, no overflow
//    (count never exceeds active).
//  - Latency: after Resync/enable cycle N, first LowClock rise at edge N+active+1.
//  - Channels fully independent; a write to one never disturbs another.
//
// STRUCTURE
//  - clkdiv_pkg: MAX_CH=16, function clog2_min1(), reset constants.
//  - Sub-module clock_divider_channel (one counter/active/pending set, LowClock,
//    RiseTick); top generates NUM_CH instances and decodes WrEn/WrChan to per-channel
//    write strobes.
//
// TESTING
//  1 Reset, ChanEn=4'b0001, DEFAULT_DIV=0 -> LowClock[0] toggles every cycle,
//    RiseTick[0] every 2nd cycle; LowClock[3:1]=0.
//  2 Write ch1 div=3, Resync, ChanEn[1]=1 -> period 8 cycles, first rise 4 edges
//    after Resync, RiseTick[1] 1 cycle wide.
//  3 Ch1 running div=3, write div=1 mid half-period -> current half-period stays
//    4 cycles, subsequent half-periods 2 cycles; no runt pulse.
//  4 Write WrChan=5 with NUM_CH=4 -> no channel's pending/active changes.
//  5 Ch0 div=2, ch2 div=5 both running, Resync -> both LowClock=0 next edge,
//    rises at +3 and +6 edges; write coincident with Resync applied only at next toggle.
//  6 Reset asserted mid-half-period with pend_vld=1 -> next edge all outputs 0,
//    active=DEFAULT_DIV, pending discarded.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared limits, reset values and width helper for the clock divider bank
package clkdiv_pkg;

  // Upper bound on channel count supported by the bank.
  localparam int MAX_CH = 16;

  // Output and flag values loaded by Reset.
  localparam logic RST_LOW_CLOCK = 1'b0;
  localparam logic RST_RISE_TICK = 1'b0;
  localparam logic RST_PEND_VLD  = 1'b0;

  // $clog2 that never returns 0, so a single-channel bank still has a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// rtl/clock_divider_channel.sv - one square-wave divider with glitch-free divisor update
//
// Ports:
//   HighClock  in   source clock, posedge
//   Reset      in   synchronous active-high
//   WrEn       in   divisor write strobe for this channel
//   WrDiv      in   new divisor (half-period = WrDiv+1 cycles)
//   ChanEn     in   run enable; low holds the channel in its restart state
//   Resync     in   restart pulse shared by all channels
//   LowClock   out  divided square wave
//   RiseTick   out  one-cycle strobe on the cycle LowClock rises
module clock_divider_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W = 32,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = '0
) (
  input  logic             HighClock,
  input  logic             Reset,
  input  logic             WrEn,
  input  logic [DIV_W-1:0] WrDiv,
  input  logic             ChanEn,
  input  logic             Resync,
  output logic             LowClock,
  output logic             RiseTick
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] activeDiv;
  logic [DIV_W-1:0] pendingDiv;
  logic             pendVld;

  logic restart;
  logic halfDone;
  logic swapPoint;

  assign restart   = Resync | ~ChanEn;
  assign halfDone  = (count == activeDiv);
  // Divisor changes only where a half-period starts fresh, so no runt pulse can appear.
  assign swapPoint = restart | halfDone;

  always_ff @(posedge HighClock) begin
    if (Reset) begin
      count      <= '0;
      activeDiv  <= DEFAULT_DIV;
      pendingDiv <= '0;
      pendVld    <= RST_PEND_VLD;
      LowClock   <= RST_LOW_CLOCK;
      RiseTick   <= RST_RISE_TICK;
    end else begin
      if (swapPoint && pendVld) begin
        activeDiv <= pendingDiv;
        pendVld   <= 1'b0;
      end
      // A write on a swap cycle wins over the clear above: it waits for the next swap.
      if (WrEn) begin
        pendingDiv <= WrDiv;
        pendVld    <= 1'b1;
      end

      if (restart) begin
        count    <= '0;
        LowClock <= 1'b0;
        RiseTick <= 1'b0;
      end else if (halfDone) begin
        count    <= '0;
        LowClock <= ~LowClock;
        RiseTick <= ~LowClock;
      end else begin
        count    <= count + DIV_W'(1);
        RiseTick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of independent runtime-programmable clock dividers
//
// Ports:
//   HighClock  in   source clock, posedge
//   Reset      in   synchronous active-high
//   WrEn       in   divisor write strobe
//   WrChan     in   target channel of the write; indices >= NUM_CH are ignored
//   WrDiv      in   new divisor (half-period = WrDiv+1 cycles)
//   ChanEn     in   per-channel run enable
//   Resync     in   restart every channel in phase
//   LowClock   out  per-channel divided square waves
//   RiseTick   out  per-channel rising-edge strobes
module clock_divider_bank
  import clkdiv_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int DIV_W       = 32,
  parameter  int DEFAULT_DIV = 0,
  localparam int CH_W        = clog2_min1(NUM_CH)
) (
  input  logic              HighClock,
  input  logic              Reset,
  input  logic              WrEn,
  input  logic [CH_W-1:0]   WrChan,
  input  logic [DIV_W-1:0]  WrDiv,
  input  logic [NUM_CH-1:0] ChanEn,
  input  logic              Resync,
  output logic [NUM_CH-1:0] LowClock,
  output logic [NUM_CH-1:0] RiseTick
);

  logic [NUM_CH-1:0] chanWrEn;

  for (genvar i = 0; i < NUM_CH; i++) begin : gChan
    // Out-of-range WrChan values simply match no channel.
    assign chanWrEn[i] = WrEn && (WrChan == CH_W'(i));

    clock_divider_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DIV_W'(DEFAULT_DIV))
    ) uChannel (
      .HighClock (HighClock),
      .Reset     (Reset),
      .WrEn      (chanWrEn[i]),
      .WrDiv     (WrDiv),
      .ChanEn    (ChanEn[i]),
      .Resync    (Resync),
      .LowClock  (LowClock[i]),
      .RiseTick  (RiseTick[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - scoreboard bench for clock_divider_bank
module tb_clock_divider_bank;

  localparam int NCH = 5;
  localparam int DW  = 8;

  logic           HighClock = 1'b0;
  logic           Reset     = 1'b1;
  logic           WrEn      = 1'b0;
  logic [2:0]     WrChan    = '0;
  logic [DW-1:0]  WrDiv     = '0;
  logic [NCH-1:0] ChanEn    = '0;
  logic           Resync    = 1'b0;
  logic [NCH-1:0] LowClock;
  logic [NCH-1:0] RiseTick;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int    edgeNum;
    int    ch;
    logic  lc;
    logic  rt;
    string tag;
  } exp_t;

  exp_t sb[$];

  clock_divider_bank #(
    .NUM_CH      (NCH),
    .DIV_W       (DW),
    .DEFAULT_DIV (0)
  ) dut (
    .HighClock (HighClock),
    .Reset     (Reset),
    .WrEn      (WrEn),
    .WrChan    (WrChan),
    .WrDiv     (WrDiv),
    .ChanEn    (ChanEn),
    .Resync    (Resync),
    .LowClock  (LowClock),
    .RiseTick  (RiseTick)
  );

  always #5 HighClock = ~HighClock;

  always @(posedge HighClock) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HighClock);
    #1;
  endtask

  task automatic push(input int e, input int ch, input logic lc, input logic rt, input string tag);
    exp_t item;
    item.edgeNum = e;
    item.ch      = ch;
    item.lc      = lc;
    item.rt      = rt;
    item.tag     = tag;
    sb.push_back(item);
  endtask

  // Channel restarted (LowClock=startLow) at edge e0 with divisor div; expected
  // output at e0+k is derived from whole half-periods elapsed.
  task automatic expectSeg(input string tag, input int ch, input int e0, input int div,
                           input logic startLow, input int kFrom, input int kTo);
    for (int k = kFrom; k <= kTo; k++) begin
      logic lc;
      logic rt;
      lc = startLow ^ (((k / (div + 1)) % 2) == 1);
      rt = (k > 0) && ((k % (div + 1)) == 0) && lc;
      push(e0 + k, ch, lc, rt, tag);
    end
  endtask

  task automatic expectIdle(input string tag, input int ch, input int e0, input int n);
    for (int k = 0; k <= n; k++) push(e0 + k, ch, 1'b0, 1'b0, tag);
  endtask

  task automatic writeDiv(input int ch, input int div);
    WrEn   = 1'b1;
    WrChan = 3'(ch);
    WrDiv  = DW'(div);
    tick();
    WrEn   = 1'b0;
  endtask

  always @(negedge HighClock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].edgeNum <= cyc) begin
        if (sb[i].edgeNum < cyc)
          checkEq({sb[i].tag, " missed"}, 32'd0, 32'd1);
        else
          checkEq($sformatf("%s ch%0d edge%0d {low,rise}", sb[i].tag, sb[i].ch, sb[i].edgeNum),
                  {30'd0, LowClock[sb[i].ch], RiseTick[sb[i].ch]},
                  {30'd0, sb[i].lc, sb[i].rt});
        sb.delete(i);
      end
    end
  end

  initial begin
    int r;
    int n;

    // 1: reset state, then default divisor 0 on ch0 only
    Reset  = 1'b1;
    ChanEn = 5'b00001;
    tick();
    tick();
    r = cyc;
    Reset = 1'b0;
    expectSeg("t1 div0", 0, r, 0, 1'b0, 0, 16);
    for (int c = 1; c < NCH; c++) expectIdle("t1 idle", c, r, 16);
    repeat (16) tick();

    // 2: ch1 div=3 started by Resync
    writeDiv(1, 3);
    tick();
    ChanEn = 5'b00011;
    Resync = 1'b1;
    tick();
    n = cyc;
    Resync = 1'b0;
    expectSeg("t2 ch0", 0, n, 0, 1'b0, 0, 20);
    expectSeg("t2 ch1", 1, n, 3, 1'b0, 0, 20);
    for (int c = 2; c < NCH; c++) expectIdle("t2 idle", c, n, 20);
    repeat (20) tick();

    // 3: write div=1 one cycle into a div=3 half-period
    Resync = 1'b1;
    tick();
    n = cyc;
    Resync = 1'b0;
    expectSeg("t3 old", 1, n, 3, 1'b0, 0, 4);
    expectSeg("t3 new", 1, n + 4, 1, 1'b1, 1, 12);
    expectSeg("t3 ch0", 0, n, 0, 1'b0, 0, 16);
    for (int c = 2; c < NCH; c++) expectIdle("t3 idle", c, n, 16);
    writeDiv(1, 1);
    repeat (15) tick();

    // 4: out-of-range writes ignored; maximum divisor on ch3
    writeDiv(3, 255);
    writeDiv(5, 7);
    writeDiv(6, 7);
    writeDiv(7, 7);
    ChanEn = 5'b11111;
    Resync = 1'b1;
    tick();
    n = cyc;
    Resync = 1'b0;
    expectSeg("t4 ch0", 0, n, 0, 1'b0, 0, 300);
    expectSeg("t4 ch1", 1, n, 1, 1'b0, 0, 300);
    expectSeg("t4 ch2", 2, n, 0, 1'b0, 0, 300);
    expectSeg("t4 ch3", 3, n, 255, 1'b0, 0, 300);
    expectSeg("t4 ch4", 4, n, 0, 1'b0, 0, 300);
    repeat (300) tick();

    // 5: ch0 div=2, ch2 div=5 running, Resync with a coincident write to ch2
    ChanEn = 5'b00101;
    writeDiv(0, 2);
    writeDiv(2, 5);
    repeat (12) tick();
    WrEn   = 1'b1;
    WrChan = 3'd2;
    WrDiv  = DW'(1);
    Resync = 1'b1;
    tick();
    n = cyc;
    WrEn   = 1'b0;
    Resync = 1'b0;
    expectSeg("t5 ch0", 0, n, 2, 1'b0, 0, 24);
    expectSeg("t5 ch2 old", 2, n, 5, 1'b0, 0, 6);
    expectSeg("t5 ch2 new", 2, n + 6, 1, 1'b1, 1, 18);
    expectIdle("t5 idle", 1, n, 24);
    expectIdle("t5 idle", 3, n, 24);
    expectIdle("t5 idle", 4, n, 24);
    repeat (24) tick();

    // 6: Reset mid half-period with a pending divisor on ch0
    writeDiv(0, 4);
    Reset = 1'b1;
    tick();
    r = cyc;
    Reset = 1'b0;
    expectSeg("t6 ch0", 0, r, 0, 1'b0, 0, 12);
    expectSeg("t6 ch2", 2, r, 0, 1'b0, 0, 12);
    expectIdle("t6 idle", 1, r, 12);
    expectIdle("t6 idle", 3, r, 12);
    expectIdle("t6 idle", 4, r, 12);
    repeat (12) tick();

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    checkEq("scoreboard drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
